// File: rtl/mpc_alpha_beta_pkg.sv
// Shared definitions for the MPC alpha/beta stage: field names, FSM states,
// the bytewise field addition and the point count per security level.
package mpc_alpha_beta_pkg;

   localparam string FIELD_GF256 = "GF256";
   localparam string FIELD_P251  = "P251";

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_REQ  = 2'd1,
      ST_MUL_WAIT = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   // Number of evaluation points: four for L5, three otherwise.
   function automatic int t_for_set(input string ps);
      return (ps == "L5") ? 4 : 3;
   endfunction

   // One byte of field addition: XOR for GF256, conditional subtract for P251.
   function automatic logic [7:0] fadd_byte(input logic is_p251,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
      logic [8:0] s;
      if (!is_p251) begin
         return x ^ y;
      end
      s = {1'b0, x} + {1'b0, y};
      if (s >= 9'd251) begin
         s = s - 9'd251;
      end
      return s[7:0];
   endfunction

endpackage

// File: rtl/mpc_alpha_beta_if.sv
// Bus between the alpha/beta stage and its surroundings: operation start and
// operands, results and status, plus the shared multiplier request/response.
// Multiplier handshake: o_start_mul is a one-cycle request; operands stay
// stable until the cycle in which i_done_mul is high, and i_o_mul is only
// sampled in that cycle.
interface mpc_alpha_beta_if #(parameter int T = 3);
   import mpc_alpha_beta_pkg::*;

   logic            i_start;
   logic [32*T-1:0] i_q_eval;
   logic [32*T-1:0] i_p_eval;
   logic [32*T-1:0] i_eps;
   logic [32*T-1:0] i_a;
   logic [32*T-1:0] i_b;
   logic [32*T-1:0] o_alpha;
   logic [32*T-1:0] o_beta;
   logic            o_busy;
   logic            o_done;
   logic            o_start_mul;
   logic [31:0]     o_x_mul;
   logic [31:0]     o_y_mul;
   logic [31:0]     i_o_mul;
   logic            i_done_mul;
   state_t          dbg_state;
   logic [7:0]      dbg_idx;

   modport slave (
      input  i_start, i_q_eval, i_p_eval, i_eps, i_a, i_b, i_o_mul, i_done_mul,
      output o_alpha, o_beta, o_busy, o_done, o_start_mul, o_x_mul, o_y_mul,
      output dbg_state, dbg_idx
   );

   modport master (
      output i_start, i_q_eval, i_p_eval, i_eps, i_a, i_b, i_o_mul, i_done_mul,
      input  o_alpha, o_beta, o_busy, o_done, o_start_mul, o_x_mul, o_y_mul,
      input  dbg_state, dbg_idx
   );

endinterface

// File: rtl/mpc_alpha_beta_gf_add_32_comb.sv
// 32-bit combinational field addition, four independent byte lanes.
module gf_add_32_comb
   import mpc_alpha_beta_pkg::*;
#(
   parameter string FIELD = FIELD_GF256
) (
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic [31:0] sum
);

   localparam logic IS_P251 = (FIELD == FIELD_P251);

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign sum[8*k +: 8] = fadd_byte(IS_P251, x[8*k +: 8], y[8*k +: 8]);
   end

endmodule

// File: rtl/mpc_alpha_beta.sv
// Computes alpha_t = eps_t*Q(r_t) + a_t and beta_t = P(r_t) + b_t one point at
// a time, using an external shared multiplier for the eps*Q product.
module mpc_alpha_beta
   import mpc_alpha_beta_pkg::*;
#(
   parameter string FIELD         = FIELD_GF256,
   parameter string PARAMETER_SET = "L1",
   parameter int    T             = t_for_set(PARAMETER_SET)
) (
   input logic            i_clk,
   input logic            i_rst,
   mpc_alpha_beta_if.slave bus
);

   state_t          state, state_nx;
   logic [32*T-1:0] q_r, p_r, eps_r, a_r, b_r;
   logic [32*T-1:0] alpha_r, beta_r;
   logic [7:0]      idx;
   logic [31:0]     a_sel, p_sel, b_sel, alpha_sum, beta_sum;
   logic            last_pt, take_prod;
   logic            busy, done, start_mul;
   logic [31:0]     x_mul, y_mul;

   assign last_pt   = (idx == 8'(T - 1));
   assign take_prod = (state == ST_MUL_WAIT) && bus.i_done_mul;
   assign a_sel     = a_r[32*idx +: 32];
   assign p_sel     = p_r[32*idx +: 32];
   assign b_sel     = b_r[32*idx +: 32];

   gf_add_32_comb #(.FIELD(FIELD)) u_add_alpha (.x(bus.i_o_mul), .y(a_sel), .sum(alpha_sum));
   gf_add_32_comb #(.FIELD(FIELD)) u_add_beta  (.x(p_sel),       .y(b_sel), .sum(beta_sum));

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // Next state and status/multiplier outputs decoded from the current state.
   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      start_mul = 1'b0;
      x_mul     = '0;
      y_mul     = '0;
      unique case (state)
         ST_IDLE: begin
            if (bus.i_start) state_nx = ST_MUL_REQ;
         end
         ST_MUL_REQ: begin
            busy      = 1'b1;
            start_mul = 1'b1;
            x_mul     = eps_r[32*idx +: 32];
            y_mul     = q_r[32*idx +: 32];
            state_nx  = ST_MUL_WAIT;
         end
         ST_MUL_WAIT: begin
            busy  = 1'b1;
            x_mul = eps_r[32*idx +: 32];
            y_mul = q_r[32*idx +: 32];
            if (bus.i_done_mul) state_nx = last_pt ? ST_DONE : ST_MUL_REQ;
         end
         ST_DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Operand latch on accepted start; per-point result write on product arrival.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         q_r     <= '0;
         p_r     <= '0;
         eps_r   <= '0;
         a_r     <= '0;
         b_r     <= '0;
         alpha_r <= '0;
         beta_r  <= '0;
         idx     <= '0;
      end else if ((state == ST_IDLE) && bus.i_start) begin
         q_r     <= bus.i_q_eval;
         p_r     <= bus.i_p_eval;
         eps_r   <= bus.i_eps;
         a_r     <= bus.i_a;
         b_r     <= bus.i_b;
         alpha_r <= '0;
         beta_r  <= '0;
         idx     <= '0;
      end else if (take_prod) begin
         alpha_r[32*idx +: 32] <= alpha_sum;
         beta_r[32*idx +: 32]  <= beta_sum;
         if (!last_pt) idx <= idx + 8'd1;
      end
   end

   assign bus.o_alpha     = alpha_r;
   assign bus.o_beta      = beta_r;
   assign bus.o_busy      = busy;
   assign bus.o_done      = done;
   assign bus.o_start_mul = start_mul;
   assign bus.o_x_mul     = x_mul;
   assign bus.o_y_mul     = y_mul;
   assign bus.dbg_state   = state;
   assign bus.dbg_idx     = idx;

endmodule

// File: tb/tb_mpc_alpha_beta.sv
// Directed bench for mpc_alpha_beta: a GF256 instance on a latency-programmable
// multiplier stub and a P251 instance on a fixed-product stub.
module tb_mpc_alpha_beta;
   import mpc_alpha_beta_pkg::*;

   localparam int T = 3;
   localparam logic [32*T-1:0] Q0 = 96'h547ecce1954b24bae61a13cf;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   mpc_alpha_beta_if #(.T(T)) bus ();
   mpc_alpha_beta_if #(.T(T)) pbus ();

   mpc_alpha_beta #(.FIELD("GF256"), .PARAMETER_SET("L1"), .T(T)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );
   mpc_alpha_beta #(.FIELD("P251"), .PARAMETER_SET("L1"), .T(T)) dut_p (
      .i_clk(clk), .i_rst(rst), .bus(pbus)
   );

   // ---------------- multiplier stubs ----------------
   // Stand-in product: exact for the field one, otherwise a fixed mixing
   // function the bench also uses to build its expected alpha values.
   function automatic logic [31:0] stub_mul(input logic [31:0] x, input logic [31:0] y);
      return (x == 32'h1) ? y : (x ^ {y[23:0], y[31:24]});
   endfunction

   int          lat [0:3] = '{3, 3, 3, 3};
   int          cnt = 0;
   int          req_n = 0;
   int          req_base = 0;
   int          done_cnt = 0;
   logic [31:0] prod = '0;
   logic        stray = 1'b0;

   always @(posedge clk or posedge rst) begin
      int li;
      if (rst) begin
         cnt   <= 0;
         req_n <= 0;
      end else if (bus.o_start_mul) begin
         li = req_n - req_base;
         if (li < 0 || li > 3) li = 0;
         cnt   <= lat[li];
         prod  <= stub_mul(bus.o_x_mul, bus.o_y_mul);
         req_n <= req_n + 1;
      end else if (cnt > 0) begin
         cnt <= cnt - 1;
      end
   end
   assign bus.i_o_mul    = prod;
   assign bus.i_done_mul = (cnt == 1) || stray;

   always @(posedge clk) if (bus.o_done) done_cnt <= done_cnt + 1;

   int pcnt = 0;
   always @(posedge clk or posedge rst) begin
      if (rst)                   pcnt <= 0;
      else if (pbus.o_start_mul) pcnt <= 2;
      else if (pcnt > 0)         pcnt <= pcnt - 1;
   end
   assign pbus.i_o_mul    = 32'hFA80_0102;
   assign pbus.i_done_mul = (pcnt == 1);

   // ---------------- scoreboard helpers ----------------
   logic [32*T-1:0] exp_alpha, exp_beta;

   task automatic build_expected(input logic [32*T-1:0] q, input logic [32*T-1:0] p,
                                 input logic [32*T-1:0] e, input logic [32*T-1:0] a,
                                 input logic [32*T-1:0] b);
      for (int t = 0; t < T; t++) begin
         exp_alpha[32*t +: 32] = stub_mul(e[32*t +: 32], q[32*t +: 32]) ^ a[32*t +: 32];
         exp_beta[32*t +: 32]  = p[32*t +: 32] ^ b[32*t +: 32];
      end
   endtask

   // Driver: one operation on the GF256 instance. cyc counts negedges after
   // the start-sampling edge until o_done (-1 on timeout). inject_k > 0 pulses
   // a second start with inverted operands at that cycle.
   task automatic run_op(input logic [32*T-1:0] q, input logic [32*T-1:0] p,
                         input logic [32*T-1:0] e, input logic [32*T-1:0] a,
                         input logic [32*T-1:0] b, input int inject_k,
                         output int cyc, output int nreq, output int ndone, output int opbad);
      int pt;
      int d0;
      bus.i_q_eval = q; bus.i_p_eval = p; bus.i_eps = e; bus.i_a = a; bus.i_b = b;
      req_base = req_n;
      d0 = done_cnt;
      cyc = -1; pt = -1; opbad = 0;
      bus.i_start = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (k == 1) bus.i_start = 1'b0;
         if (inject_k > 0 && k == inject_k) begin
            bus.i_start = 1'b1;
            bus.i_q_eval = ~q; bus.i_p_eval = ~p; bus.i_eps = ~e; bus.i_a = ~a; bus.i_b = ~b;
         end
         if (inject_k > 0 && k == inject_k + 1) bus.i_start = 1'b0;
         if (bus.o_start_mul) pt++;
         if (bus.o_busy && !bus.o_done && pt >= 0 && pt < T) begin
            if (bus.o_x_mul !== e[32*pt +: 32] || bus.o_y_mul !== q[32*pt +: 32]) opbad++;
         end
         if (bus.o_done) begin
            cyc = k;
            break;
         end
      end
      repeat (3) @(negedge clk);
      ndone = done_cnt - d0;
      nreq  = req_n - req_base;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      total++; if (bus.o_alpha !== '0) begin bad++; $display("FAIL reset_alpha: got %h want 0", bus.o_alpha); end
      total++; if (bus.o_beta !== '0) begin bad++; $display("FAIL reset_beta: got %h want 0", bus.o_beta); end
      total++; if ({bus.o_busy, bus.o_done, bus.o_start_mul} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {bus.o_busy, bus.o_done, bus.o_start_mul}); end
      total++; if ({bus.o_x_mul, bus.o_y_mul} !== 64'h0) begin bad++; $display("FAIL reset_operands: got %h want 0", {bus.o_x_mul, bus.o_y_mul}); end
      total++; if (bus.dbg_state !== ST_IDLE || bus.dbg_idx !== 8'd0) begin bad++; $display("FAIL reset_state: got %0d/%0d want 0/0", bus.dbg_state, bus.dbg_idx); end
   endtask

   task automatic test_basic();
      int cyc, nreq, ndone, opbad;
      lat = '{3, 3, 3, 3};
      run_op(Q0, {T{32'h11111111}}, {T{32'h00000001}}, '0, {T{32'h22222222}}, 0, cyc, nreq, ndone, opbad);
      total++; if (cyc !== 13) begin bad++; $display("FAIL basic_latency: got %0d want 13", cyc); end
      total++; if (nreq !== 3) begin bad++; $display("FAIL basic_mul_requests: got %0d want 3", nreq); end
      total++; if (ndone !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", ndone); end
      total++; if (opbad !== 0) begin bad++; $display("FAIL basic_operands: got %0d bad cycles want 0", opbad); end
      total++; if (bus.o_alpha !== Q0) begin bad++; $display("FAIL basic_alpha: got %h want %h", bus.o_alpha, Q0); end
      total++; if (bus.o_beta !== {T{32'h33333333}}) begin bad++; $display("FAIL basic_beta: got %h want %h", bus.o_beta, {T{32'h33333333}}); end
      total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL basic_idle_after: busy got %b want 0", bus.o_busy); end
   endtask

   task automatic test_p251();
      int cyc;
      pbus.i_q_eval = {T{32'h01020304}};
      pbus.i_eps    = {T{32'h00000001}};
      pbus.i_a      = {T{32'h018000FA}};
      pbus.i_p_eval = {T{32'h01020304}};
      pbus.i_b      = {T{32'h00FA7D05}};
      cyc = -1;
      @(negedge clk);
      pbus.i_start = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (k == 1) pbus.i_start = 1'b0;
         if (pbus.o_done) begin cyc = k; break; end
      end
      // FA+01=251->00, 80+80=256->05, 01+00=01, 02+FA=252->01
      total++; if (pbus.o_alpha !== {T{32'h00050101}}) begin bad++; $display("FAIL p251_alpha: got %h want %h", pbus.o_alpha, {T{32'h00050101}}); end
      // 01+00=01, 02+FA=252->01, 03+7D=80, 04+05=09
      total++; if (pbus.o_beta !== {T{32'h01018009}}) begin bad++; $display("FAIL p251_beta: got %h want %h", pbus.o_beta, {T{32'h01018009}}); end
      total++; if (cyc !== 10) begin bad++; $display("FAIL p251_latency: got %0d want 10", cyc); end
   endtask

   localparam logic [32*T-1:0] VQ = {32'hdeadbeef, 32'h0badf00d, 32'hcafebabe};
   localparam logic [32*T-1:0] VE = {32'h00000003, 32'h80000001, 32'h12345678};
   localparam logic [32*T-1:0] VA = {32'h0f0f0f0f, 32'hffffffff, 32'h01234567};
   localparam logic [32*T-1:0] VP = {32'h89abcdef, 32'h00ff00ff, 32'h13572468};
   localparam logic [32*T-1:0] VB = {32'h5a5a5a5a, 32'h0000ffff, 32'hf0e1d2c3};

   task automatic test_var_latency();
      int cyc, nreq, ndone, opbad;
      lat = '{1, 7, 2, 3};
      build_expected(VQ, VP, VE, VA, VB);
      run_op(VQ, VP, VE, VA, VB, 0, cyc, nreq, ndone, opbad);
      total++; if (cyc !== 14) begin bad++; $display("FAIL var_latency: got %0d want 14", cyc); end
      total++; if (opbad !== 0) begin bad++; $display("FAIL var_operands_stable: got %0d bad cycles want 0", opbad); end
      total++; if (bus.o_alpha !== exp_alpha) begin bad++; $display("FAIL var_alpha: got %h want %h", bus.o_alpha, exp_alpha); end
      total++; if (bus.o_beta !== exp_beta) begin bad++; $display("FAIL var_beta: got %h want %h", bus.o_beta, exp_beta); end
   endtask

   task automatic test_start_busy();
      int cyc, nreq, ndone, opbad;
      lat = '{3, 3, 3, 3};
      build_expected(VQ, VP, VE, VA, VB);
      run_op(VQ, VP, VE, VA, VB, 3, cyc, nreq, ndone, opbad);
      total++; if (cyc !== 13) begin bad++; $display("FAIL busy_latency: got %0d want 13", cyc); end
      total++; if (ndone !== 1 || nreq !== 3) begin bad++; $display("FAIL busy_counts: got done=%0d req=%0d want 1/3", ndone, nreq); end
      total++; if (opbad !== 0) begin bad++; $display("FAIL busy_operands: got %0d bad cycles want 0", opbad); end
      total++; if (bus.o_alpha !== exp_alpha) begin bad++; $display("FAIL busy_alpha: got %h want %h", bus.o_alpha, exp_alpha); end
      total++; if (bus.o_beta !== exp_beta) begin bad++; $display("FAIL busy_beta: got %h want %h", bus.o_beta, exp_beta); end
   endtask

   task automatic test_reset_mid();
      int cyc, nreq, ndone, opbad;
      lat = '{3, 3, 3, 3};
      bus.i_q_eval = VQ; bus.i_p_eval = VP; bus.i_eps = VE; bus.i_a = VA; bus.i_b = VB;
      req_base = req_n;
      bus.i_start = 1'b1;
      // k=1 REQ t0, k=2..4 WAIT t0, k=5 REQ t1, k=6 WAIT t1
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) bus.i_start = 1'b0;
      end
      total++; if (bus.o_alpha === '0) begin bad++; $display("FAIL mid_partial_alpha: got %h want nonzero t0 result", bus.o_alpha); end
      #2 rst = 1'b1;
      #1;
      total++; if (bus.o_alpha !== '0 || bus.o_beta !== '0) begin bad++; $display("FAIL mid_async_results: got %h/%h want 0", bus.o_alpha, bus.o_beta); end
      total++; if ({bus.o_busy, bus.o_start_mul, bus.o_done} !== 3'b000 || bus.dbg_state !== ST_IDLE) begin bad++; $display("FAIL mid_async_state: flags %b state %0d want 000/0", {bus.o_busy, bus.o_start_mul, bus.o_done}, bus.dbg_state); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      @(negedge clk);
      total++; if (bus.dbg_state !== ST_IDLE || bus.dbg_idx !== 8'd0 || bus.o_alpha !== '0) begin bad++; $display("FAIL mid_stray_done: state %0d idx %0d alpha %h want 0/0/0", bus.dbg_state, bus.dbg_idx, bus.o_alpha); end
      build_expected(VQ, VP, VE, VA, VB);
      run_op(VQ, VP, VE, VA, VB, 0, cyc, nreq, ndone, opbad);
      total++; if (cyc !== 13 || ndone !== 1) begin bad++; $display("FAIL mid_restart_timing: got cyc=%0d done=%0d want 13/1", cyc, ndone); end
      total++; if (bus.o_alpha !== exp_alpha || bus.o_beta !== exp_beta) begin bad++; $display("FAIL mid_restart_results: got %h/%h want %h/%h", bus.o_alpha, bus.o_beta, exp_alpha, exp_beta); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.i_start = 1'b0; bus.i_q_eval = '0; bus.i_p_eval = '0; bus.i_eps = '0; bus.i_a = '0; bus.i_b = '0;
      pbus.i_start = 1'b0; pbus.i_q_eval = '0; pbus.i_p_eval = '0; pbus.i_eps = '0; pbus.i_a = '0; pbus.i_b = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_basic();
      test_p251();
      test_var_latency();
      test_start_busy();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
